// File: rtl/sys_bus.sv
`default_nettype none
// ============================================================================
// Module   : sys_bus
// Purpose  : Two-master / two-slave shared bus with a registered grant arbiter,
//            address decode to two slaves and one-cycle read-data return.
// Revision : 1.0 - initial release
// ============================================================================
module sys_bus #(
    parameter logic [7:0] S0_LAST = 8'h0F
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic        m0_wr,
    input  logic [7:0]  m0_address,
    input  logic [31:0] m0_dout,
    input  logic        m1_req,
    input  logic        m1_wr,
    input  logic [7:0]  m1_address,
    input  logic [31:0] m1_dout,
    input  logic [31:0] s0_dout,
    input  logic [31:0] s1_dout,
    output logic        m0_grant,
    output logic        m1_grant,
    output logic [31:0] m_din,
    output logic        s0_sel,
    output logic        s1_sel,
    output logic        s_wr,
    output logic [7:0]  s_address,
    output logic [31:0] s_din
);

    typedef enum logic [0:0] {
        M0_GRANT = 1'b0,
        M1_GRANT = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [1:0]  r_rd_sel;
    logic        w_gnt_m1;
    logic        w_req;
    logic        w_wr;
    logic        w_active;

    // Grants come straight from the state flop, so they are registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= M0_GRANT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Master 0 is the default owner; an owner holding req is never preempted.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            M0_GRANT: if (!m0_req && m1_req) w_state_next = M1_GRANT;
            M1_GRANT: if (!m1_req)           w_state_next = M0_GRANT;
            default:                         w_state_next = M0_GRANT;
        endcase
    end

    assign m0_grant = (r_state == M0_GRANT);
    assign m1_grant = (r_state == M1_GRANT);

    assign w_gnt_m1  = (r_state == M1_GRANT);
    assign w_req     = w_gnt_m1 ? m1_req     : m0_req;
    assign w_wr      = w_gnt_m1 ? m1_wr      : m0_wr;
    assign s_address = w_gnt_m1 ? m1_address : m0_address;
    assign s_din     = w_gnt_m1 ? m1_dout    : m0_dout;

    // Reset suppresses all slave-side strobes, independent of request inputs.
    assign w_active = w_req & ~reset;
    assign s_wr     = w_active & w_wr;
    assign s0_sel   = w_active & (s_address <= S0_LAST);
    assign s1_sel   = w_active & (s_address >  S0_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_sel <= 2'b00;
        end else begin
            r_rd_sel <= {s1_sel, s0_sel};
        end
    end

    // Read data follows the slave addressed in the previous cycle.
    always_comb begin
        m_din = 32'h0;
        case (r_rd_sel)
            2'b01:   m_din = s0_dout;
            2'b10:   m_din = s1_dout;
            default: m_din = 32'h0;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_sys_bus.sv
`default_nettype none
// ============================================================================
// Module   : tb_sys_bus
// Purpose  : Self-checking bench for sys_bus against a behavioural bus model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sys_bus;

    localparam logic [7:0] S0_LAST = 8'h0F;

    logic        clk;
    logic        reset;
    logic        m0_req, m0_wr, m1_req, m1_wr;
    logic [7:0]  m0_address, m1_address;
    logic [31:0] m0_dout, m1_dout, s0_dout, s1_dout;
    logic        m0_grant, m1_grant, s0_sel, s1_sel, s_wr;
    logic [31:0] m_din, s_din;
    logic [7:0]  s_address;

    int checks = 0;
    int errors = 0;

    // Model: which master owns the bus, and which slave (-1 none) was addressed last cycle.
    int owner = 0;
    int prev_slave = -1;

    sys_bus #(.S0_LAST(S0_LAST)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_wr(m0_wr), .m0_address(m0_address), .m0_dout(m0_dout),
        .m1_req(m1_req), .m1_wr(m1_wr), .m1_address(m1_address), .m1_dout(m1_dout),
        .s0_dout(s0_dout), .s1_dout(s1_dout),
        .m0_grant(m0_grant), .m1_grant(m1_grant), .m_din(m_din),
        .s0_sel(s0_sel), .s1_sel(s1_sel), .s_wr(s_wr),
        .s_address(s_address), .s_din(s_din)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int model_slave();
        logic       req;
        logic [7:0] addr;
        req  = (owner == 1) ? m1_req : m0_req;
        addr = (owner == 1) ? m1_address : m0_address;
        if (reset || !req) return -1;
        return (addr <= S0_LAST) ? 0 : 1;
    endfunction

    function automatic logic [31:0] model_rdata();
        if (prev_slave == 0) return s0_dout;
        if (prev_slave == 1) return s1_dout;
        return 32'h0;
    endfunction

    // Let inputs settle; an asserted reset takes effect immediately in the model too.
    task automatic settle();
        if (reset) begin
            owner = 0;
            prev_slave = -1;
        end
        #1;
    endtask

    // Advance one clock; model update uses the inputs present at the edge.
    task automatic tick();
        @(posedge clk);
        if (reset) begin
            owner = 0;
            prev_slave = -1;
        end else begin
            prev_slave = model_slave();
            if (owner == 0 && !m0_req && m1_req) owner = 1;
            else if (owner == 1 && !m1_req)      owner = 0;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; m0_req = 1'b1; m1_req = 1'b1; m0_wr = 1'b1; m1_wr = 1'b1;
        m0_address = 8'h03; m1_address = 8'h40;
        settle();
        checks++;
        if ({m0_grant, m1_grant, s0_sel, s1_sel, s_wr} !== 5'b10000 || m_din !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: got g=%b%b sel=%b%b wr=%b din=%h want g=10 sel=00 wr=0 din=0",
                     m0_grant, m1_grant, s0_sel, s1_sel, s_wr, m_din);
        end
        tick();
        m0_req = 1'b0; m1_req = 1'b0; reset = 1'b0;
        settle();
        checks++;
        if ({m0_grant, m1_grant, s0_sel, s1_sel, s_wr} !== 5'b10000 || m_din !== 32'h0) begin
            errors++;
            $display("FAIL idle_after_reset: got g=%b%b sel=%b%b wr=%b din=%h want g=10 sel=00 wr=0 din=0",
                     m0_grant, m1_grant, s0_sel, s1_sel, s_wr, m_din);
        end
        tick();
    endtask

    task automatic test_m0_write();
        m0_req = 1'b1; m0_wr = 1'b1; m0_address = 8'h02; m0_dout = 32'h1;
        m1_req = 1'b1; m1_wr = 1'b0; m1_address = 8'h80; m1_dout = 32'hDEAD_BEEF;
        settle();
        checks++;
        if ({s0_sel, s1_sel, s_wr} !== 3'b101 || s_din !== 32'h1 || s_address !== 8'h02) begin
            errors++;
            $display("FAIL m0_write: got sel=%b%b wr=%b din=%h addr=%h want sel=10 wr=1 din=1 addr=02",
                     s0_sel, s1_sel, s_wr, s_din, s_address);
        end
        tick();
        checks++;
        if ({m0_grant, m1_grant} !== 2'b10) begin
            errors++;
            $display("FAIL m0_keeps_bus: got g=%b%b want 10", m0_grant, m1_grant);
        end
    endtask

    task automatic test_m1_read();
        logic [31:0] d;
        m0_req = 1'b0; m1_req = 1'b1; m1_wr = 1'b0; m1_address = 8'h10;
        settle();
        checks++;
        if ({m0_grant, m1_grant, s0_sel, s1_sel} !== 4'b1000) begin
            errors++;
            $display("FAIL m1_wait: got g=%b%b sel=%b%b want g=10 sel=00", m0_grant, m1_grant, s0_sel, s1_sel);
        end
        tick();
        checks++;
        if ({m0_grant, m1_grant, s0_sel, s1_sel, s_wr} !== 5'b01010) begin
            errors++;
            $display("FAIL m1_granted: got g=%b%b sel=%b%b wr=%b want g=01 sel=01 wr=0",
                     m0_grant, m1_grant, s0_sel, s1_sel, s_wr);
        end
        d = $urandom; s1_dout = d; s0_dout = ~d;
        tick();
        settle();
        checks++;
        if (m_din !== d) begin
            errors++;
            $display("FAIL m1_read_data: got %h want %h", m_din, d);
        end
    endtask

    task automatic test_hold();
        logic [31:0] d;
        m0_req = 1'b1; m0_address = 8'h01;
        for (int i = 0; i < 22; i++) begin
            tick();
            checks++;
            if ({m0_grant, m1_grant} !== 2'b01) begin
                errors++;
                $display("FAIL hold_cycle%0d: got g=%b%b want 01", i, m0_grant, m1_grant);
            end
        end
        d = $urandom; s1_dout = d;
        m1_req = 1'b0;
        settle();
        checks++;
        if ({s0_sel, s1_sel, s_wr} !== 3'b000 || m_din !== d) begin
            errors++;
            $display("FAIL owner_drop: got sel=%b%b wr=%b din=%h want sel=00 wr=0 din=%h",
                     s0_sel, s1_sel, s_wr, m_din, d);
        end
        tick();
        checks++;
        if ({m0_grant, m1_grant} !== 2'b10) begin
            errors++;
            $display("FAIL handback: got g=%b%b want 10", m0_grant, m1_grant);
        end
    endtask

    task automatic test_boundary();
        logic [31:0] a, b;
        a = $urandom; b = $urandom;
        s0_dout = a; s1_dout = b;
        m0_req = 1'b1; m0_wr = 1'b0; m0_address = 8'h0F;
        settle();
        checks++;
        if ({s0_sel, s1_sel} !== 2'b10) begin
            errors++;
            $display("FAIL bound_0F_sel: got sel=%b%b want 10", s0_sel, s1_sel);
        end
        tick();
        m0_address = 8'h10;
        settle();
        checks++;
        if ({s0_sel, s1_sel} !== 2'b01 || m_din !== a) begin
            errors++;
            $display("FAIL bound_10_sel: got sel=%b%b din=%h want sel=01 din=%h", s0_sel, s1_sel, m_din, a);
        end
        tick();
        m0_req = 1'b0;
        settle();
        checks++;
        if (m_din !== b) begin
            errors++;
            $display("FAIL bound_10_data: got %h want %h", m_din, b);
        end
        tick();
        checks++;
        if (m_din !== 32'h0) begin
            errors++;
            $display("FAIL idle_data: got %h want 0", m_din);
        end
    endtask

    task automatic test_reset_mid();
        m0_req = 1'b0; m1_req = 1'b1; m1_address = 8'h20; m1_wr = 1'b1;
        tick();
        checks++;
        if ({m0_grant, m1_grant, s1_sel} !== 3'b011) begin
            errors++;
            $display("FAIL pre_reset_m1: got g=%b%b s1=%b want g=01 s1=1", m0_grant, m1_grant, s1_sel);
        end
        reset = 1'b1;
        settle();
        checks++;
        if ({m0_grant, m1_grant, s0_sel, s1_sel, s_wr} !== 5'b10000 || m_din !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid: got g=%b%b sel=%b%b wr=%b din=%h want g=10 sel=00 wr=0 din=0",
                     m0_grant, m1_grant, s0_sel, s1_sel, s_wr, m_din);
        end
        tick();
        reset = 1'b0;
        settle();
        checks++;
        if ({m0_grant, m1_grant} !== 2'b10) begin
            errors++;
            $display("FAIL post_reset_owner: got g=%b%b want 10", m0_grant, m1_grant);
        end
        tick();
        checks++;
        if ({m0_grant, m1_grant} !== 2'b01) begin
            errors++;
            $display("FAIL rearbitrate: got g=%b%b want 01", m0_grant, m1_grant);
        end
    endtask

    task automatic test_random();
        logic        g_req, g_wr;
        logic [7:0]  g_addr;
        logic [31:0] g_dout;
        logic [4:0]  exp_ctl;
        logic [31:0] exp_rd;
        for (int i = 0; i < 400; i++) begin
            reset   = ($urandom_range(0, 39) == 0);
            m0_req  = ($urandom_range(0, 2) != 0);
            m1_req  = ($urandom_range(0, 2) != 0);
            m0_wr   = $urandom_range(0, 1);
            m1_wr   = $urandom_range(0, 1);
            m0_address = ($urandom_range(0, 1) == 1) ? 8'(S0_LAST + $urandom_range(0, 1)) : 8'($urandom);
            m1_address = ($urandom_range(0, 1) == 1) ? 8'(S0_LAST + $urandom_range(0, 1)) : 8'($urandom);
            m0_dout = $urandom; m1_dout = $urandom;
            s0_dout = $urandom; s1_dout = $urandom;
            settle();
            g_req  = (owner == 1) ? m1_req : m0_req;
            g_wr   = (owner == 1) ? m1_wr : m0_wr;
            g_addr = (owner == 1) ? m1_address : m0_address;
            g_dout = (owner == 1) ? m1_dout : m0_dout;
            exp_ctl = {owner == 0, owner == 1, model_slave() == 0, model_slave() == 1,
                       !reset && g_req && g_wr};
            exp_rd  = model_rdata();
            checks++;
            if ({m0_grant, m1_grant, s0_sel, s1_sel, s_wr} !== exp_ctl ||
                s_address !== g_addr || s_din !== g_dout || m_din !== exp_rd) begin
                errors++;
                $display("FAIL random_%0d: got ctl=%b addr=%h din=%h mdin=%h want ctl=%b addr=%h din=%h mdin=%h",
                         i, {m0_grant, m1_grant, s0_sel, s1_sel, s_wr}, s_address, s_din, m_din,
                         exp_ctl, g_addr, g_dout, exp_rd);
            end
            tick();
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        m0_req = 1'b0; m0_wr = 1'b0; m0_address = 8'h0; m0_dout = 32'h0;
        m1_req = 1'b0; m1_wr = 1'b0; m1_address = 8'h0; m1_dout = 32'h0;
        s0_dout = 32'h0; s1_dout = 32'h0;
        test_reset();
        test_m0_write();
        test_m1_read();
        test_hold();
        test_boundary();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
